// File: rtl/n_bit_accumulator.sv
// Burst accumulator: adds LEN handshaked operands into an N-bit register and returns sum + sticky carry.
// Optional feature: define ACC_SATURATE_EN to clamp the accumulator to all-ones on carry-out.
module n_bit_accumulator #(
  parameter int N       = 32,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic [N-1:0]       init,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_sum,
  output logic               out_cout,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state;
  logic [N-1:0]       acc;
  logic [COUNT_W-1:0] remaining;
  logic               cflag;
  logic [N:0]         sum;
  logic [N-1:0]       acc_next;
  logic               beat;

  assign sum  = {1'b0, acc} + {1'b0, in_data};
  assign beat = in_valid && in_ready;

`ifdef ACC_SATURATE_EN
  // Once saturated, acc + x >= all-ones keeps carrying, so acc stays pinned.
  assign acc_next = sum[N] ? {N{1'b1}} : sum[N-1:0];
`else
  assign acc_next = sum[N-1:0];
`endif

  // acc and cflag are registers, so the result ports are registered as well.
  assign out_sum  = acc;
  assign out_cout = cflag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      cflag     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= init;
            cflag <= 1'b0;
            busy  <= 1'b1;
            if (len != '0) begin
              remaining <= len;
              in_ready  <= 1'b1;
              state     <= ACCUM;
            end else begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc       <= acc_next;
            cflag     <= cflag | sum[N];
            remaining <= remaining - 1'b1;
            if (remaining == COUNT_W'(1)) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
